// File: rtl/snoopy_motion_ctrl_pkg.sv
// Shared motion definitions: jump state encoding and default sprite geometry,
// used by the motion controller and the renderer.
package snoopy_motion_ctrl_pkg;

  localparam int unsigned POS_X_W = 8;
  localparam int unsigned POS_Y_W = 7;

  localparam int unsigned DEF_TICK_DIV = 833333;
  localparam int unsigned DEF_X_MIN    = 0;
  localparam int unsigned DEF_X_MAX    = 152;
  localparam int unsigned DEF_X_START  = 76;
  localparam int unsigned DEF_Y_GROUND = 100;
  localparam int unsigned DEF_JUMP_H   = 30;

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } jump_state_e;

endpackage

// File: rtl/snoopy_motion_ctrl_if.sv
// Key levels in, sprite position/state out; slave side is the controller.
interface snoopy_motion_ctrl_if;
  import snoopy_motion_ctrl_pkg::*;

  logic               input_up;
  logic               input_left;
  logic               input_right;
  logic [POS_X_W-1:0] pos_x;
  logic [POS_Y_W-1:0] pos_y;
  logic               jumping;
  logic               facing_left;
  logic               tick;

  modport master (
    output input_up, input_left, input_right,
    input  pos_x, pos_y, jumping, facing_left, tick
  );

  modport slave (
    input  input_up, input_left, input_right,
    output pos_x, pos_y, jumping, facing_left, tick
  );
endinterface

// File: rtl/snoopy_motion_ctrl_tick_gen.sv
// Free-running divider; tick is a registered pulse during the cycle the count is TICK_DIV-1.
module tick_gen
  import snoopy_motion_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // tick is registered from the next count so it lines up with cnt_q == LAST
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_nxt;
      tick  <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/snoopy_motion_ctrl.sv
// Sprite motion: saturating horizontal walk and a fixed-height jump, updated once per tick.
module snoopy_motion_ctrl
  import snoopy_motion_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned X_MIN    = DEF_X_MIN,
  parameter int unsigned X_MAX    = DEF_X_MAX,
  parameter int unsigned X_START  = DEF_X_START,
  parameter int unsigned Y_GROUND = DEF_Y_GROUND,
  parameter int unsigned JUMP_H   = DEF_JUMP_H
) (
  input  logic                 clk,
  input  logic                 reset,
  snoopy_motion_ctrl_if.slave  bus
);

  localparam logic [POS_X_W-1:0] XMIN_V  = POS_X_W'(X_MIN);
  localparam logic [POS_X_W-1:0] XMAX_V  = POS_X_W'(X_MAX);
  localparam logic [POS_X_W-1:0] XSTRT_V = POS_X_W'(X_START);
  localparam logic [POS_Y_W-1:0] YGND_V  = POS_Y_W'(Y_GROUND);
  localparam logic [POS_Y_W-1:0] YTOP_V  = POS_Y_W'(Y_GROUND - JUMP_H);

  jump_state_e        state_q, state_nxt;
  logic [POS_X_W-1:0] pos_x_q, pos_x_nxt;
  logic [POS_Y_W-1:0] pos_y_q, pos_y_nxt;
  logic               facing_q, facing_nxt;
  logic               jumping_q, jumping_nxt;
  logic               req_q, req_nxt;
  logic               up_prev_q;
  logic               tick;
  logic               up_edge;
  logic               left_only;
  logic               right_only;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign up_edge    = bus.input_up & ~up_prev_q;
  assign left_only  = bus.input_left & ~bus.input_right;
  assign right_only = bus.input_right & ~bus.input_left;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= GROUND;
      pos_x_q   <= XSTRT_V;
      pos_y_q   <= YGND_V;
      facing_q  <= 1'b0;
      jumping_q <= 1'b0;
      req_q     <= 1'b0;
      up_prev_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      pos_x_q   <= pos_x_nxt;
      pos_y_q   <= pos_y_nxt;
      facing_q  <= facing_nxt;
      jumping_q <= jumping_nxt;
      req_q     <= req_nxt;
      up_prev_q <= bus.input_up;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    pos_x_nxt  = pos_x_q;
    pos_y_nxt  = pos_y_q;
    facing_nxt = facing_q;
    req_nxt    = req_q;

    // Request uses the pre-tick value, so an edge on a tick is served next tick
    if (state_q != GROUND || (tick && req_q)) begin
      req_nxt = 1'b0;
    end else if (up_edge) begin
      req_nxt = 1'b1;
    end

    if (tick) begin
      if (left_only) begin
        facing_nxt = 1'b1;
        if (pos_x_q > XMIN_V) pos_x_nxt = pos_x_q - POS_X_W'(1);
      end else if (right_only) begin
        facing_nxt = 1'b0;
        if (pos_x_q < XMAX_V) pos_x_nxt = pos_x_q + POS_X_W'(1);
      end

      // Takeoff tick moves nothing vertically, giving 2*JUMP_H ticks per jump
      unique case (state_q)
        GROUND: begin
          if (req_q) state_nxt = RISE;
        end
        RISE: begin
          pos_y_nxt = pos_y_q - POS_Y_W'(1);
          if (pos_y_nxt == YTOP_V) state_nxt = FALL;
        end
        FALL: begin
          pos_y_nxt = pos_y_q + POS_Y_W'(1);
          if (pos_y_nxt == YGND_V) state_nxt = GROUND;
        end
        default: state_nxt = GROUND;
      endcase
    end

    jumping_nxt = (state_nxt != GROUND);
  end

  assign bus.pos_x       = pos_x_q;
  assign bus.pos_y       = pos_y_q;
  assign bus.jumping     = jumping_q;
  assign bus.facing_left = facing_q;
  assign bus.tick        = tick;

endmodule

// File: doc/snoopy_motion_ctrl.md
SNOOPY_MOTION_CTRL -- requirements
Module: snoopy_motion_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 833333, meaning clk cycles per motion tick (60 Hz at 50 MHz).
REQ-002 Parameter X_MIN, default 0, meaning leftmost legal pos_x.
REQ-003 Parameter X_MAX, default 152, meaning rightmost legal pos_x.
REQ-004 Parameter X_START, default 76, meaning pos_x after reset.
REQ-005 Parameter Y_GROUND, default 100, meaning pos_y when standing.
REQ-006 Parameter JUMP_H, default 30, meaning jump apex height in pixels (Y_GROUND-JUMP_H >= 0).
REQ-007 clk  input  1  system clock (one clock domain, 50 MHz).
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 input_up  input  1  level, high while up key held (from keyboard FSM).
REQ-010 input_left  input  1  level, high while left key held.
REQ-011 input_right  input  1  level, high while right key held.
REQ-012 pos_x  output  8  sprite x position, unsigned.
REQ-013 pos_y  output  7  sprite y position, unsigned, smaller = higher on screen.
REQ-014 jumping  output  1  high whenever jump state is not GROUND.
REQ-015 facing_left  output  1  last horizontal direction commanded.
REQ-016 tick  output  1  one-clk pulse marking each motion update.

Function
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high exactly in the cycle the counter equals TICK_DIV-1.
REQ-018 All position/state updates SHALL occur only on clk edges where tick is high; outputs SHALL be registered (visible the cycle after tick).
REQ-019 Horizontal: left-only -> pos_x decrements by 1; right-only -> increments by 1; both or neither -> unchanged.
REQ-020 pos_x SHALL saturate: no decrement at X_MIN, no increment at X_MAX; never wraps.
REQ-021 facing_left SHALL be set on a tick with left-only, cleared on a tick with right-only, else held.
REQ-022 Jump request flag SHALL set on any clk where input_up is high and was low the previous clk (edge detect, independent of tick).
REQ-023 Jump FSM states GROUND, RISE, FALL; GROUND with request at tick -> RISE and request cleared.
REQ-024 RISE: pos_y decrements by 1 per tick; on the tick where pos_y reaches Y_GROUND-JUMP_H -> FALL.
REQ-025 FALL: pos_y increments by 1 per tick; on the tick where pos_y reaches Y_GROUND -> GROUND.
REQ-026 Edges of input_up while in RISE or FALL SHALL be discarded (request flag held clear); holding up does not retrigger after landing.
REQ-027 A full jump SHALL take exactly 2*JUMP_H ticks from leaving GROUND to re-entering GROUND.
REQ-028 Horizontal movement SHALL proceed independently during RISE and FALL.
REQ-029 Simultaneous up edge and tick in GROUND: edge is captured and consumed at the next tick, not the same one.

Reset
REQ-030 On reset assertion, immediately (asynchronously): pos_x=X_START, pos_y=Y_GROUND, state=GROUND, jumping=0, facing_left=0, tick=0, counter=0, request=0, up edge-detect history=0.
REQ-031 Reset mid-jump SHALL abort the jump with no residual request; first tick after release occurs TICK_DIV clks after reset deasserts.

Structure
REQ-032 Jump state encoding (GROUND/RISE/FALL) and default geometry constants SHALL live in a shared package used also by the renderer.
REQ-033 The tick generator SHALL be a sub-module named tick_gen (parameter TICK_DIV, outputs tick).

Verification (TICK_DIV=4, X_MIN=0, X_MAX=10, X_START=5, Y_GROUND=20, JUMP_H=3)
REQ-034 Hold input_right 8 ticks -> pos_x 5,6,...,10 then stays 10; facing_left=0.
REQ-035 Hold input_left and input_right together 3 ticks -> pos_x stays 5, facing_left unchanged.
REQ-036 Pulse input_up 1 clk in GROUND -> pos_y 19,18,17,18,19,20 on successive ticks; jumping high for 6 ticks, then 0.
REQ-037 Second input_up edge during RISE -> ignored; exactly one jump; held up after landing -> no new jump.
REQ-038 Assert reset while pos_y=18 in RISE -> pos_y=20, jumping=0, pos_x=5 same cycle; no jump after release.
REQ-039 Check tick period: pulses exactly every 4 clks, first at clk 4 after reset release.
